// File: rtl/eea3_pkg.sv
// Shared definitions for the 128-EEA3 stream engine: FSM encoding plus the
// IV construction and tail-keep mask helpers.
package eea3_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_INIT   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    // IV byte i sits in bits [8i+7:8i]; the upper 64 bits repeat the lower 64.
    function automatic logic [127:0] eea3_iv(
        input logic [31:0] count,
        input logic [4:0]  bearer,
        input logic        direction
    );
        logic [63:0] half;
        half = {24'h00_0000, bearer, direction, 2'b00,
                count[7:0], count[15:8], count[23:16], count[31:24]};
        return {half, half};
    endfunction

    // Keeps the first 'tail' message bits (MSB first); tail 0 means a full word.
    function automatic logic [31:0] tail_mask(input logic [4:0] tail);
        logic [31:0] mask;
        if (tail == 5'd0) begin
            mask = 32'hFFFF_FFFF;
        end else begin
            mask = ~(32'hFFFF_FFFF >> tail);
        end
        return mask;
    endfunction

endpackage

// File: rtl/eea3_stream_if.sv
// Bundle of command, zuc control, keystream, input and output handshakes
// around the EEA3 stream engine.
interface eea3_stream_if #(
    parameter int LEN_W = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_count;
    logic [4:0]       cmd_bearer;
    logic             cmd_direction;
    logic [127:0]     cmd_ck;
    logic [LEN_W-1:0] cmd_length;

    logic             z_valid;
    logic             z_ready;
    logic             z_init;
    logic [127:0]     z_iv;
    logic [127:0]     z_key;

    logic             ks_valid;
    logic             ks_ready;
    logic [31:0]      ks_data;

    logic             s_valid;
    logic             s_ready;
    logic [31:0]      s_data;

    logic             m_valid;
    logic             m_ready;
    logic [31:0]      m_data;
    logic             m_last;

    modport slave (
        input  cmd_valid, cmd_count, cmd_bearer, cmd_direction, cmd_ck, cmd_length,
        input  z_ready, ks_valid, ks_data, s_valid, s_data, m_ready,
        output cmd_ready, z_valid, z_init, z_iv, z_key, ks_ready, s_ready,
        output m_valid, m_data, m_last
    );

    modport master (
        output cmd_valid, cmd_count, cmd_bearer, cmd_direction, cmd_ck, cmd_length,
        output z_ready, ks_valid, ks_data, s_valid, s_data, m_ready,
        input  cmd_ready, z_valid, z_init, z_iv, z_key, ks_ready, s_ready,
        input  m_valid, m_data, m_last
    );

endinterface

// File: rtl/eea3_stream.sv
// 128-EEA3 confidentiality engine: initialises zuc per command, then XORs
// keystream with data words and zeroes the bits past the message length.
module eea3_stream
    import eea3_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input logic           clk,
    input logic           rst,
    eea3_stream_if.slave  bus
);

    localparam logic [LEN_W-5:0] WL_ONE = {{(LEN_W-5){1'b0}}, 1'b1};

    logic [1:0]       state_r;
    logic [127:0]     z_key_r;
    logic [127:0]     z_iv_r;
    logic [LEN_W-5:0] words_left_r;
    logic [4:0]       tail_r;
    logic             m_valid_r;
    logic             m_last_r;
    logic [31:0]      m_data_r;

    logic [LEN_W:0]   len_round_s;
    logic             cmd_ready_s;
    logic             z_valid_s;
    logic             z_init_s;
    logic             ks_ready_s;
    logic             s_ready_s;
    logic             out_free_s;
    logic             xfer_s;
    logic             final_s;
    logic [31:0]      word_s;

    // One extra bit so a length near the top of the range cannot wrap when rounded up.
    assign len_round_s = {1'b0, bus.cmd_length} + {{(LEN_W-4){1'b0}}, 5'd31};
    assign final_s     = (words_left_r == WL_ONE);

    // Handshake decode and the masked XOR word for the current transfer.
    always_comb begin
        cmd_ready_s = 1'b0;
        z_valid_s   = 1'b0;
        z_init_s    = 1'b0;
        ks_ready_s  = 1'b0;
        s_ready_s   = 1'b0;
        out_free_s  = !m_valid_r || bus.m_ready;
        case (state_r)
            ST_IDLE: begin
                cmd_ready_s = 1'b1;
            end
            ST_INIT: begin
                z_valid_s = 1'b1;
                z_init_s  = 1'b1;
            end
            ST_STREAM: begin
                z_valid_s  = 1'b1;
                ks_ready_s = bus.s_valid && out_free_s;
                s_ready_s  = bus.ks_valid && out_free_s;
            end
            ST_DRAIN: begin
                cmd_ready_s = 1'b0;
            end
            default: begin
                cmd_ready_s = 1'b0;
            end
        endcase
        xfer_s = (state_r == ST_STREAM) && bus.ks_valid && bus.s_valid && out_free_s;
        word_s = (bus.s_data ^ bus.ks_data) & (final_s ? tail_mask(tail_r) : 32'hFFFF_FFFF);
    end

    // Message FSM, command latches and word countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            z_key_r      <= 128'd0;
            z_iv_r       <= 128'd0;
            words_left_r <= '0;
            tail_r       <= 5'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        z_key_r      <= bus.cmd_ck;
                        z_iv_r       <= eea3_iv(bus.cmd_count, bus.cmd_bearer, bus.cmd_direction);
                        words_left_r <= len_round_s[LEN_W:5];
                        tail_r       <= bus.cmd_length[4:0];
                        // An empty message is accepted and dropped without touching zuc.
                        state_r      <= (bus.cmd_length == '0) ? ST_IDLE : ST_INIT;
                    end
                end
                ST_INIT: begin
                    if (bus.z_ready) begin
                        state_r <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (xfer_s) begin
                        words_left_r <= words_left_r - WL_ONE;
                        if (final_s) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.m_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output register: loads on every transfer, clears valid once it is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            m_data_r  <= 32'd0;
        end else if (xfer_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= word_s;
            m_last_r  <= final_s;
        end else if (bus.m_ready) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end
    end

    assign bus.cmd_ready = cmd_ready_s;
    assign bus.z_valid   = z_valid_s;
    assign bus.z_init    = z_init_s;
    assign bus.z_iv      = z_iv_r;
    assign bus.z_key     = z_key_r;
    assign bus.ks_ready  = ks_ready_s;
    assign bus.s_ready   = s_ready_s;
    assign bus.m_valid   = m_valid_r;
    assign bus.m_data    = m_data_r;
    assign bus.m_last    = m_last_r;

endmodule
